avalon_pwm_multi: RTL and testbench

AVALON_PWM_MULTI -- requirements
Module: avalon_pwm_multi

---
 rtl/avalon_pwm_pkg.sv | 34 +++
 rtl/pwm_channel.sv | 48 ++++
 rtl/avalon_pwm_multi.sv | 115 +++++++++++
 tb/tb_avalon_pwm_multi.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/avalon_pwm_pkg.sv
// Register map, CTRL bit positions and address decode shared by the PWM block.
// Latency: none (declarations and a combinational helper only).
// Backpressure: not applicable.
package avalon_pwm_pkg;

    localparam logic [4:0] ADDR_CTRL      = 5'd0;
    localparam logic [4:0] ADDR_PERIOD    = 5'd1;
    localparam logic [4:0] ADDR_DUTY_BASE = 5'd2;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_INV_BIT = 1;
    localparam int CTRL_W       = 2;

    typedef enum logic [1:0] {
        SEL_NONE,
        SEL_CTRL,
        SEL_PERIOD,
        SEL_DUTY
    } reg_sel_e;

    function automatic reg_sel_e decode_addr(input logic [4:0] addr, input int channels);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_CTRL) begin
            sel = SEL_CTRL;
        end else if (addr == ADDR_PERIOD) begin
            sel = SEL_PERIOD;
        end else if (int'(addr) < int'(ADDR_DUTY_BASE) + channels) begin
            sel = SEL_DUTY;
        end
        return sel;
    endfunction

endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: duty shadow/active pair, counter compare and output polarity.
// Latency: pwm_out follows the counter by one cycle; duty writes land in the shadow next cycle.
// Backpressure: none; writes are always accepted.
module pwm_channel #(
    parameter int CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wr_en,
    input  logic [CNT_WIDTH-1:0] wr_dat,
    input  logic                 load,
    input  logic [CNT_WIDTH-1:0] cnt,
    input  logic                 enable,
    input  logic                 invert,
    output logic [CNT_WIDTH-1:0] shadow,
    output logic                 pwm_out
);

    logic [CNT_WIDTH-1:0] duty_shadow_q, duty_shadow_d;
    logic [CNT_WIDTH-1:0] duty_active_q, duty_active_d;
    logic                 pwm_q, pwm_d;
    logic                 raw;

    always_comb begin
        duty_shadow_d = wr_en ? wr_dat : duty_shadow_q;
        // The active copy takes the shadow as it was before any same-cycle write.
        duty_active_d = load ? duty_shadow_q : duty_active_q;
        raw           = (cnt < duty_active_q);
        pwm_d         = enable && (raw ^ invert);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_shadow_q <= '0;
            duty_active_q <= '0;
            pwm_q         <= 1'b0;
        end else begin
            duty_shadow_q <= duty_shadow_d;
            duty_active_q <= duty_active_d;
            pwm_q         <= pwm_d;
        end
    end

    assign shadow = duty_shadow_q;
    // Gate with the live enable so a disable forces the pin low without waiting a cycle.
    assign pwm_out = pwm_q & enable;

endmodule

// File: rtl/avalon_pwm_multi.sv
// Multi-channel PWM generator with an Avalon-MM slave for CTRL/PERIOD/DUTY registers.
// Latency: writes apply next cycle, readdata 1 cycle after read, pwm_out 1 cycle after counter.
// Backpressure: none; the slave accepts every read and write with no wait states.
module avalon_pwm_multi
    import avalon_pwm_pkg::*;
#(
    parameter int CHANNELS  = 4,
    parameter int CNT_WIDTH = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [4:0]          address,
    input  logic                write,
    input  logic [31:0]         writedata,
    input  logic                read,
    output logic [31:0]         readdata,
    output logic [CHANNELS-1:0] pwm_out,
    output logic                period_tick
);

    logic [CTRL_W-1:0]    ctrl_q, ctrl_d;
    logic [CNT_WIDTH-1:0] period_shadow_q, period_shadow_d;
    logic [CNT_WIDTH-1:0] period_active_q, period_active_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic [31:0]          readdata_q, readdata_d;

    reg_sel_e             sel;
    logic [4:0]           duty_off;
    logic                 en;
    logic                 inv;
    logic                 at_top;
    logic                 wrap;
    logic                 load;
    logic [CHANNELS-1:0]  duty_wr;
    logic [CNT_WIDTH-1:0] duty_shadow [CHANNELS];
    logic [CNT_WIDTH-1:0] duty_rd;
    logic                 unused_wdata;

    assign unused_wdata = ^writedata;

    always_comb begin
        sel      = decode_addr(address, CHANNELS);
        duty_off = address - ADDR_DUTY_BASE;
        en       = ctrl_q[CTRL_EN_BIT];
        inv      = ctrl_q[CTRL_INV_BIT];
        at_top   = (cnt_q == period_active_q);
        wrap     = en && at_top;
        // Shadows are copied continuously while disabled so enabling starts from fresh values.
        load     = wrap || !en;

        cnt_d           = (en && !at_top) ? cnt_q + CNT_WIDTH'(1) : '0;
        ctrl_d          = (write && sel == SEL_CTRL) ? writedata[CTRL_W-1:0] : ctrl_q;
        period_shadow_d = (write && sel == SEL_PERIOD) ? writedata[CNT_WIDTH-1:0]
                                                       : period_shadow_q;
        period_active_d = load ? period_shadow_q : period_active_q;
    end

    always_comb begin
        duty_rd = '0;
        for (int n = 0; n < CHANNELS; n++) begin
            if (duty_off == 5'(n)) begin
                duty_rd = duty_shadow[n];
            end
        end

        readdata_d = readdata_q;
        if (read) begin
            case (sel)
                SEL_CTRL:   readdata_d = 32'(ctrl_q);
                SEL_PERIOD: readdata_d = 32'(period_shadow_q);
                SEL_DUTY:   readdata_d = 32'(duty_rd);
                default:    readdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctrl_q          <= '0;
            period_shadow_q <= '1;
            period_active_q <= '1;
            cnt_q           <= '0;
            readdata_q      <= '0;
        end else begin
            ctrl_q          <= ctrl_d;
            period_shadow_q <= period_shadow_d;
            period_active_q <= period_active_d;
            cnt_q           <= cnt_d;
            readdata_q      <= readdata_d;
        end
    end

    for (genvar n = 0; n < CHANNELS; n++) begin : g_ch
        assign duty_wr[n] = write && (sel == SEL_DUTY) && (duty_off == 5'(n));

        pwm_channel #(
            .CNT_WIDTH(CNT_WIDTH)
        ) u_ch (
            .clk    (clk),
            .reset  (reset),
            .wr_en  (duty_wr[n]),
            .wr_dat (writedata[CNT_WIDTH-1:0]),
            .load   (load),
            .cnt    (cnt_q),
            .enable (en),
            .invert (inv),
            .shadow (duty_shadow[n]),
            .pwm_out(pwm_out[n])
        );
    end

    assign readdata    = readdata_q;
    assign period_tick = wrap;

endmodule

// File: tb/tb_avalon_pwm_multi.sv
// Self-checking bench for avalon_pwm_multi: register table, PWM waveforms, shadow timing, reset.
module tb_avalon_pwm_multi;

    localparam int CHANNELS  = 4;
    localparam int CNT_WIDTH = 8;
    localparam int NVEC      = 23;

    logic                clk;
    logic                reset;
    logic [4:0]          address;
    logic                write;
    logic [31:0]         writedata;
    logic                read;
    logic [31:0]         readdata;
    logic [CHANNELS-1:0] pwm_out;
    logic                period_tick;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        wr;
        logic [4:0]  addr;
        logic [31:0] data;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[NVEC];

    avalon_pwm_multi #(
        .CHANNELS (CHANNELS),
        .CNT_WIDTH(CNT_WIDTH)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .write      (write),
        .writedata  (writedata),
        .read       (read),
        .readdata   (readdata),
        .pwm_out    (pwm_out),
        .period_tick(period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
        address   = a;
        writedata = d;
        write     = 1'b1;
        @(negedge clk);
        write     = 1'b0;
    endtask

    task automatic do_read(input logic [4:0] a, input logic [31:0] e);
        address = a;
        read    = 1'b1;
        exp_q.push_back(e);
        @(negedge clk);
        read = 1'b0;
        check($sformatf("read_a%0d", a), readdata, exp_q.pop_front());
    endtask

    // Disable, set DUTY[0], then re-enable; returns on the first enabled cycle (counter 0).
    task automatic restart(input logic [31:0] ctrl_val, input logic [31:0] d0);
        write_reg(5'd0, 32'd0);
        write_reg(5'd2, d0);
        write_reg(5'd0, ctrl_val);
    endtask

    // Sample k=1 is the first enabled cycle (counter 0); PERIOD is 9 throughout.
    // Channel 0 uses duty da for periods before pchange and db afterwards;
    // channels 1..3 hold duties 0, 10 and 255.
    task automatic run_check(input string tag, input int n, input int wr_k,
                             input logic [4:0] wa, input logic [31:0] wd,
                             input int da, input int db, input int pchange, input logic inv);
        logic [3:0] exp_pwm;
        logic       exp_tick;
        int         c;
        int         d;
        for (int k = 1; k <= n; k++) begin
            exp_tick = (((k - 1) % 10) == 9);
            if (k < 2) begin
                exp_pwm = 4'b0000;
            end else begin
                c = (k - 2) % 10;
                d = (((k - 2) / 10) < pchange) ? da : db;
                exp_pwm[0] = (c < d) ^ inv;
                exp_pwm[1] = 1'b0 ^ inv;
                exp_pwm[2] = 1'b1 ^ inv;
                exp_pwm[3] = 1'b1 ^ inv;
            end
            check($sformatf("%s_pwm_k%0d", tag, k), 32'(pwm_out), 32'(exp_pwm));
            check($sformatf("%s_tick_k%0d", tag, k), 32'(period_tick), 32'(exp_tick));
            if (k == wr_k) begin
                address   = wa;
                writedata = wd;
                write     = 1'b1;
            end else begin
                write = 1'b0;
            end
            @(negedge clk);
        end
        write = 1'b0;
    endtask

    initial begin
        vecs[0]  = '{1'b0, 5'd1,  32'd0,          32'd255};
        vecs[1]  = '{1'b0, 5'd2,  32'd0,          32'd0};
        vecs[2]  = '{1'b0, 5'd0,  32'd0,          32'd0};
        vecs[3]  = '{1'b1, 5'd1,  32'd9,          32'd0};
        vecs[4]  = '{1'b0, 5'd1,  32'd0,          32'd9};
        vecs[5]  = '{1'b1, 5'd2,  32'd3,          32'd0};
        vecs[6]  = '{1'b0, 5'd2,  32'd0,          32'd3};
        vecs[7]  = '{1'b1, 5'd3,  32'd0,          32'd0};
        vecs[8]  = '{1'b0, 5'd3,  32'd0,          32'd0};
        vecs[9]  = '{1'b1, 5'd4,  32'd10,         32'd0};
        vecs[10] = '{1'b0, 5'd4,  32'd0,          32'd10};
        vecs[11] = '{1'b1, 5'd5,  32'h1FF,        32'd0};
        vecs[12] = '{1'b0, 5'd5,  32'd0,          32'hFF};
        vecs[13] = '{1'b1, 5'd0,  32'hFFFF_FFFC,  32'd0};
        vecs[14] = '{1'b0, 5'd0,  32'd0,          32'd0};
        vecs[15] = '{1'b1, 5'd20, 32'hFFFF_FFFF,  32'd0};
        vecs[16] = '{1'b0, 5'd20, 32'd0,          32'd0};
        vecs[17] = '{1'b0, 5'd6,  32'd0,          32'd0};
        vecs[18] = '{1'b0, 5'd31, 32'd0,          32'd0};
        vecs[19] = '{1'b0, 5'd1,  32'd0,          32'd9};
        vecs[20] = '{1'b0, 5'd2,  32'd0,          32'd3};
        vecs[21] = '{1'b0, 5'd0,  32'd0,          32'd0};
        vecs[22] = '{1'b0, 5'd5,  32'd0,          32'hFF};

        reset     = 1'b1;
        write     = 1'b0;
        read      = 1'b0;
        address   = '0;
        writedata = '0;
        repeat (3) @(negedge clk);
        check("reset_pwm", 32'(pwm_out), 32'd0);
        check("reset_tick", 32'(period_tick), 32'd0);
        check("reset_rdata", readdata, 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_pwm", 32'(pwm_out), 32'd0);

        for (int i = 0; i < NVEC; i++) begin
            if (vecs[i].wr) write_reg(vecs[i].addr, vecs[i].data);
            else            do_read(vecs[i].addr, vecs[i].exp);
        end
        @(negedge clk);
        check("rdata_hold", readdata, 32'hFF);

        write_reg(5'd0, 32'd1);
        run_check("basic", 30, 0, 5'd0, 32'd0, 3, 3, 99, 1'b0);

        restart(32'd1, 32'd3);
        run_check("mid", 30, 5, 5'd2, 32'd7, 3, 7, 1, 1'b0);

        restart(32'd1, 32'd3);
        run_check("wrap", 30, 10, 5'd2, 32'd5, 3, 5, 2, 1'b0);

        restart(32'd3, 32'd3);
        run_check("inv", 20, 0, 5'd0, 32'd0, 3, 3, 99, 1'b1);
        write_reg(5'd0, 32'd2);
        for (int k = 0; k < 4; k++) begin
            check($sformatf("dis_pwm_%0d", k), 32'(pwm_out), 32'd0);
            check($sformatf("dis_tick_%0d", k), 32'(period_tick), 32'd0);
            @(negedge clk);
        end

        write_reg(5'd1, 32'd0);
        write_reg(5'd0, 32'd1);
        for (int k = 1; k <= 6; k++) begin
            check($sformatf("p0_tick_k%0d", k), 32'(period_tick), 32'd1);
            check($sformatf("p0_pwm_k%0d", k), 32'(pwm_out), (k < 2) ? 32'd0 : 32'b1101);
            @(negedge clk);
        end

        write_reg(5'd0, 32'd0);
        write_reg(5'd1, 32'd9);
        write_reg(5'd0, 32'd1);
        repeat (4) @(negedge clk);
        check("pre_rst_pwm", 32'(pwm_out), 32'b1100);
        #1 reset = 1'b1;
        #1;
        check("async_rst_pwm", 32'(pwm_out), 32'd0);
        check("async_rst_tick", 32'(period_tick), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            check($sformatf("after_rst_pwm_%0d", k), 32'(pwm_out), 32'd0);
            check($sformatf("after_rst_tick_%0d", k), 32'(period_tick), 32'd0);
            @(negedge clk);
        end
        do_read(5'd1, 32'd255);
        do_read(5'd2, 32'd0);
        do_read(5'd0, 32'd0);
        do_read(5'd5, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
